// File: rtl/reduction_tree_ctrl.sv
// Sequencer for the 64-pair FP32 reduction tree: credit-based frame admission, latency tracking, result FIFO.
// Optional performance counters are enabled with the REDUCTION_TREE_CTRL_PERF_EN macro.
module reduction_tree_ctrl #(
  parameter int TREE_LAT   = 21,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] num_frames,
  output logic               busy,
  output logic               done,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               tree_issue,
  input  logic [31:0]        tree_result,
  output logic               res_valid,
  output logic [31:0]        res_data,
  output logic [FRAME_W-1:0] res_tag,
  input  logic               res_ready
`ifdef REDUCTION_TREE_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_bp_cycles,
  output logic [31:0]        perf_job_cycles
`endif
);

  localparam int INF_W = $clog2(TREE_LAT + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int CRD_W = ((INF_W > CNT_W) ? INF_W : CNT_W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] frames_total, issued;
  logic [TREE_LAT-1:0] pipe_v;
  logic [FRAME_W-1:0] pipe_tag [TREE_LAT];
  logic [INF_W-1:0]   inflight;
  logic [31:0]        fifo_data [FIFO_DEPTH];
  logic [FRAME_W-1:0] fifo_tag  [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               start_acc, retire, pop, credit_ok;

  // Every frame in the tree already owns a FIFO slot, so a retiring result always has room.
  assign credit_ok = (CRD_W'(inflight) + CRD_W'(fifo_cnt)) < CRD_W'(FIFO_DEPTH);
  assign retire    = pipe_v[TREE_LAT-1];
  assign pop       = res_valid & res_ready;

  always_comb begin
    state_nxt  = state;
    start_acc  = 1'b0;
    busy       = (state == RUN) || (state == DRAIN);
    done       = (state == DONE);
    in_ready   = (state == RUN) && (issued < frames_total) && credit_ok;
    tree_issue = in_valid & in_ready;
    res_valid  = (fifo_cnt != '0);
    res_data   = res_valid ? fifo_data[rd_ptr] : '0;
    res_tag    = res_valid ? fifo_tag[rd_ptr] : '0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = (num_frames == '0) ? DONE : RUN;
        end
      end
      RUN:     if (issued == frames_total) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0 && fifo_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      frames_total <= '0;
      issued       <= '0;
      pipe_v       <= '0;
      for (int i = 0; i < TREE_LAT; i++) pipe_tag[i] <= '0;
      inflight     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        frames_total <= num_frames;
        issued       <= '0;
      end else if (tree_issue) begin
        issued <= issued + 1'b1;
      end
      pipe_v[0]   <= tree_issue;
      pipe_tag[0] <= issued;
      for (int i = 1; i < TREE_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
      if (tree_issue && !retire)      inflight <= inflight + 1'b1;
      else if (!tree_issue && retire) inflight <= inflight - 1'b1;
      if (retire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (retire && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!retire && pop) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // Storage is left unreset; validity is carried entirely by fifo_cnt.
  always_ff @(posedge clk) begin
    if (retire) begin
      fifo_data[wr_ptr] <= tree_result;
      fifo_tag[wr_ptr]  <= pipe_tag[TREE_LAT-1];
    end
  end

`ifdef REDUCTION_TREE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      perf_stall_cycles <= '0;
      perf_bp_cycles    <= '0;
      perf_job_cycles   <= '0;
    end else begin
      if (state == RUN && in_valid && !in_ready && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (res_valid && !res_ready && perf_bp_cycles != '1)
        perf_bp_cycles <= perf_bp_cycles + 1'b1;
      if (state != IDLE && perf_job_cycles != '1)
        perf_job_cycles <= perf_job_cycles + 1'b1;
    end
  end
`endif

endmodule
